// File: rtl/interval_timer.sv
// Multi-channel interval timer: each channel counts a programmable period and emits a
// one-cycle tick at every wrap, in periodic or one-shot mode, with double-buffered config.
module interval_timer #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 1000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_asyn,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic                 cfg_oneshot,
    input  logic [NUM_CH-1:0]    start,
    input  logic [NUM_CH-1:0]    stop,
    input  logic                 pause,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_WIDTH-1:0] sp_q, sp_d;
        logic [CNT_WIDTH-1:0] ap_q, ap_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 sm_q, sm_d;
        logic                 am_q, am_d;
        logic                 tick_q, tick_d;
        state_e               state_q, state_d;
        logic                 cfg_hit;
        logic                 start_ok;
        logic                 wrap;

        // Addresses at or above NUM_CH never match any channel, so they drop out here.
        assign cfg_hit  = cfg_we && (cfg_ch == CH_W'(gi));
        assign start_ok = start[gi] && (sp_q != '0);
        assign wrap     = (cnt_q == ap_q - ONE);

        always_comb begin
            sp_d    = sp_q;
            sm_d    = sm_q;
            ap_d    = ap_q;
            am_d    = am_q;
            cnt_d   = cnt_q;
            state_d = state_q;
            tick_d  = 1'b0;

            if (cfg_hit) begin
                sp_d = cfg_period;
                sm_d = cfg_oneshot;
            end

            if (stop[gi]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (start_ok) begin
                cnt_d   = '0;
                ap_d    = sp_q;
                am_d    = sm_q;
                state_d = RUN;
            end else if (state_q == RUN && !pause) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    // A zero shadow period is never made active, keeping CNT below AP.
                    if (sp_q != '0) begin
                        ap_d = sp_q;
                        am_d = sm_q;
                    end
                    if (am_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset_asyn) begin
                sp_q    <= RST_PERIOD;
                sm_q    <= 1'b0;
                ap_q    <= RST_PERIOD;
                am_q    <= 1'b0;
                cnt_q   <= '0;
                tick_q  <= 1'b0;
                state_q <= IDLE;
            end else begin
                sp_q    <= sp_d;
                sm_q    <= sm_d;
                ap_q    <= ap_d;
                am_q    <= am_d;
                cnt_q   <= cnt_d;
                tick_q  <= tick_d;
                state_q <= state_d;
            end
        end

        assign tick[gi] = tick_q;
        assign busy[gi] = (state_q == RUN);
    end

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: directed scenarios with literal tick times, then random
// traffic, all compared each cycle against an absolute-deadline reference model.
module tb_interval_timer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int DEF_P  = 1000;
    localparam int CH_W   = 2;

    logic              clk;
    logic              reset_asyn;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic              pause;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    interval_timer #(
        .NUM_CH(NUM_CH),
        .CNT_WIDTH(CNT_W),
        .DEFAULT_PERIOD(DEF_P)
    ) dut (
        .clk(clk),
        .reset_asyn(reset_asyn),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .start(start),
        .stop(stop),
        .pause(pause),
        .tick(tick),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each running channel holds the absolute edge number of its next tick.
    int                m_sp[NUM_CH];
    bit                m_sm[NUM_CH];
    bit                m_run[NUM_CH];
    bit                m_mode[NUM_CH];
    int                m_deadline[NUM_CH];
    logic [NUM_CH-1:0] exp_tick = '0;
    logic [NUM_CH-1:0] exp_busy = '0;

    int tq[NUM_CH][$];
    bit tick_busy[NUM_CH];

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_tick[i] = 1'b0;
            if (reset_asyn) begin
                m_sp[i]   = DEF_P;
                m_sm[i]   = 1'b0;
                m_run[i]  = 1'b0;
                m_mode[i] = 1'b0;
            end else begin
                if (stop[i]) begin
                    m_run[i] = 1'b0;
                end else if (start[i] && m_sp[i] != 0) begin
                    m_run[i]      = 1'b1;
                    m_deadline[i] = cyc + m_sp[i];
                    m_mode[i]     = m_sm[i];
                end else if (m_run[i]) begin
                    if (pause) begin
                        m_deadline[i]++;
                    end else if (cyc == m_deadline[i]) begin
                        exp_tick[i] = 1'b1;
                        if (m_mode[i]) begin
                            m_run[i] = 1'b0;
                        end else begin
                            m_deadline[i] = cyc + m_sp[i];
                            m_mode[i]     = m_sm[i];
                        end
                    end
                end
                if (cfg_we && cfg_ch == i) begin
                    m_sp[i] = int'(cfg_period);
                    m_sm[i] = cfg_oneshot;
                end
            end
            exp_busy[i] = m_run[i];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL tick_cmp edge=%0d got=%b exp=%b", cyc, tick, exp_tick);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy_cmp edge=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick[i] === 1'b1) begin
                    tq[i].push_back(cyc);
                    tick_busy[i] = busy[i];
                end
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    function automatic int tick_at(input int ch, input int k);
        if (tq[ch].size() > k) return tq[ch][k];
        return -1;
    endfunction

    task automatic cfg_write(input int ch, input int p, input bit os);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_period  = CNT_W'(p);
        cfg_oneshot = os;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns the edge number at which the start was sampled.
    task automatic pulse_start(input logic [NUM_CH-1:0] m, output int t);
        @(negedge clk);
        start = m;
        @(negedge clk);
        start = '0;
        t = cyc;
    endtask

    task automatic pulse_stop(input logic [NUM_CH-1:0] m);
        @(negedge clk);
        stop = m;
        @(negedge clk);
        stop = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t;

    initial begin
        reset_asyn  = 1'b1;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        cfg_oneshot = 1'b0;
        start       = '0;
        stop        = '0;
        pause       = 1'b0;
        wait_cycles(3);
        reset_asyn = 1'b0;
        check_eq("reset_tick", int'(tick), 0);
        check_eq("reset_busy", int'(busy), 0);

        // Default period on ch0: ticks at +1000, +2000, +3000.
        tq[0].delete();
        pulse_start(4'b0001, t);
        check_eq("ch0_busy_after_start", int'(busy[0]), 1);
        wait_cycles(3005);
        check_eq("ch0_tick_count", tq[0].size(), 3);
        check_eq("ch0_tick1", tick_at(0, 0) - t, 1000);
        check_eq("ch0_tick2", tick_at(0, 1) - t, 2000);
        check_eq("ch0_tick3", tick_at(0, 2) - t, 3000);
        pulse_stop(4'b0001);

        // One-shot P=5 on ch1.
        cfg_write(1, 5, 1'b1);
        tq[1].delete();
        pulse_start(4'b0010, t);
        wait_cycles(20);
        check_eq("ch1_oneshot_count", tq[1].size(), 1);
        check_eq("ch1_oneshot_time", tick_at(1, 0) - t, 5);
        check_eq("ch1_busy_at_tick", int'(tick_busy[1]), 0);
        check_eq("ch1_busy_end", int'(busy[1]), 0);

        // Periodic P=4 on ch2, shadow rewritten to 7 mid-interval.
        cfg_write(2, 4, 1'b0);
        tq[2].delete();
        pulse_start(4'b0100, t);
        wait_cycles(1);
        cfg_write(2, 7, 1'b0);
        wait_cycles(25);
        check_eq("ch2_tick1", tick_at(2, 0) - t, 4);
        check_eq("ch2_tick2", tick_at(2, 1) - t, 11);
        check_eq("ch2_tick3", tick_at(2, 2) - t, 18);
        pulse_stop(4'b0100);

        // ch0 P=3 with a 10-cycle pause right after start.
        cfg_write(0, 3, 1'b0);
        tq[0].delete();
        pulse_start(4'b0001, t);
        pause = 1'b1;
        wait_cycles(10);
        pause = 1'b0;
        wait_cycles(10);
        check_eq("ch0_pause_tick1", tick_at(0, 0) - t, 13);
        check_eq("ch0_pause_tick2", tick_at(0, 1) - t, 16);
        pulse_stop(4'b0001);

        // ch3: start+stop together, then stop on the terminal count.
        cfg_write(3, 6, 1'b0);
        tq[3].delete();
        @(negedge clk);
        start = 4'b1000;
        stop  = 4'b1000;
        @(negedge clk);
        start = '0;
        stop  = '0;
        check_eq("ch3_startstop_busy", int'(busy[3]), 0);
        pulse_start(4'b1000, t);
        wait_cycles(5);
        stop = 4'b1000;
        @(negedge clk);
        stop = '0;
        wait_cycles(10);
        check_eq("ch3_no_tick", tq[3].size(), 0);
        check_eq("ch3_idle", int'(busy[3]), 0);

        // Zero period start is ignored.
        cfg_write(1, 0, 1'b0);
        pulse_start(4'b0010, t);
        check_eq("ch1_p0_busy", int'(busy[1]), 0);
        wait_cycles(5);
        check_eq("ch1_p0_busy_later", int'(busy[1]), 0);

        // Reset mid-run on all channels, coinciding with start and cfg_we.
        cfg_write(1, 9, 1'b0);
        pulse_start(4'b1111, t);
        wait_cycles(4);
        check_eq("all_busy_before_reset", int'(busy), 15);
        @(negedge clk);
        reset_asyn  = 1'b1;
        start       = 4'b1111;
        cfg_we      = 1'b1;
        cfg_ch      = '0;
        cfg_period  = 16'd50;
        @(negedge clk);
        check_eq("reset_mid_tick", int'(tick), 0);
        check_eq("reset_mid_busy", int'(busy), 0);
        reset_asyn = 1'b0;
        start      = '0;
        cfg_we     = 1'b0;
        tq[0].delete();
        pulse_start(4'b0001, t);
        wait_cycles(1002);
        check_eq("sp_default_after_reset", tick_at(0, 0) - t, 1000);
        pulse_stop(4'b0001);

        // Random traffic, checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset_asyn  = ($urandom_range(0, 499) == 0);
            cfg_we      = ($urandom_range(0, 5) == 0);
            cfg_ch      = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_period  = CNT_W'($urandom_range(1, 12));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            pause       = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                start[i] = ($urandom_range(0, 15) == 0);
                stop[i]  = ($urandom_range(0, 39) == 0);
            end
        end
        @(negedge clk);
        reset_asyn = 1'b0;
        cfg_we     = 1'b0;
        pause      = 1'b0;
        start      = '0;
        stop       = '0;
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
